// File: rtl/pa_fpu_frbus_wb_if.sv
// pa_fpu_frbus_wb_if
//   Bundles the writeback result bus of the FPU: the two result offers
//   (datapath stage ex2, divide/sqrt unit), the register-file write offer,
//   flush, and the fflags clear/report pair.
//   Modports:
//     slave  - the writeback queue (pa_fpu_frbus_wb) side
//     master - the surrounding pipeline / register-file side
interface pa_fpu_frbus_wb_if;
  // datapath ex2 result offer
  logic        dp_frbus_ex2_vld;
  logic [31:0] dp_frbus_ex2_data;
  logic [4:0]  dp_frbus_ex2_fflags;
  logic [4:0]  dp_frbus_ex2_rd;
  logic        frbus_dp_ready;
  // divide/sqrt result offer
  logic        fdsu_frbus_vld;
  logic [31:0] fdsu_frbus_data;
  logic [4:0]  fdsu_frbus_fflags;
  logic [4:0]  fdsu_frbus_rd;
  logic        frbus_fdsu_ready;
  // register-file write offer
  logic        frbus_rf_wb_vld;
  logic [31:0] frbus_rf_wb_data;
  logic [4:0]  frbus_rf_wb_rd;
  logic        rf_frbus_wb_ready;
  // control / flags
  logic        rtu_yy_xx_flush;
  logic        cp0_fpu_fflags_clr;
  logic [4:0]  frbus_cp0_fflags;

  modport slave (
    input  dp_frbus_ex2_vld, dp_frbus_ex2_data, dp_frbus_ex2_fflags, dp_frbus_ex2_rd,
    output frbus_dp_ready,
    input  fdsu_frbus_vld, fdsu_frbus_data, fdsu_frbus_fflags, fdsu_frbus_rd,
    output frbus_fdsu_ready,
    output frbus_rf_wb_vld, frbus_rf_wb_data, frbus_rf_wb_rd,
    input  rf_frbus_wb_ready,
    input  rtu_yy_xx_flush, cp0_fpu_fflags_clr,
    output frbus_cp0_fflags
  );

  modport master (
    output dp_frbus_ex2_vld, dp_frbus_ex2_data, dp_frbus_ex2_fflags, dp_frbus_ex2_rd,
    input  frbus_dp_ready,
    output fdsu_frbus_vld, fdsu_frbus_data, fdsu_frbus_fflags, fdsu_frbus_rd,
    input  frbus_fdsu_ready,
    input  frbus_rf_wb_vld, frbus_rf_wb_data, frbus_rf_wb_rd,
    output rf_frbus_wb_ready,
    output rtu_yy_xx_flush, cp0_fpu_fflags_clr,
    input  frbus_cp0_fflags
  );
endinterface

// File: rtl/pa_fpu_frbus_wb.sv
// pa_fpu_frbus_wb
//   FPU result writeback queue. Two producers (datapath ex2 and divide/sqrt)
//   push {data, fflags, rd} into a DEPTH-entry circular FIFO; the head is
//   offered to the floating-point register file.
//   Ports:
//     forever_cpuclk - clock, rising edge
//     cpurst         - synchronous active-high reset
//     bus            - pa_fpu_frbus_wb_if.slave (offers, wb offer, flush, fflags)
//   Parameter DEPTH: queue entries, power of two in 2..8.
//   Build option PA_FPU_FRBUS_FFLAGS_ACCUM_EN:
//     defined   - frbus_cp0_fflags is a sticky OR of fflags of dequeued
//                 results, cleared by cp0_fpu_fflags_clr
//     undefined - frbus_cp0_fflags shows the head fflags in a dequeue cycle,
//                 else 0; cp0_fpu_fflags_clr has no effect
module pa_fpu_frbus_wb #(
  parameter int DEPTH = 4
) (
  input logic             forever_cpuclk,
  input logic             cpurst,
  pa_fpu_frbus_wb_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  fflags;
    logic [4:0]  rd;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   free;
  logic            dp_acc;
  logic            fdsu_acc;
  logic            deq;
  logic [PW-1:0]   fdsu_wptr;
  entry_t          head;

  // Readiness looks only at the registered count, so a dequeue in the same
  // cycle never makes room for an incoming result.
  assign free                 = DEPTH_C - count;
  assign bus.frbus_dp_ready   = (free != '0);
  assign bus.frbus_fdsu_ready = (free >= CW'(2)) ||
                                ((free == CW'(1)) && !bus.dp_frbus_ex2_vld);

  assign dp_acc   = bus.dp_frbus_ex2_vld && bus.frbus_dp_ready;
  assign fdsu_acc = bus.fdsu_frbus_vld && bus.frbus_fdsu_ready;

  assign head                 = mem[rptr];
  assign bus.frbus_rf_wb_vld  = (count != '0);
  assign bus.frbus_rf_wb_data = head.data;
  assign bus.frbus_rf_wb_rd   = head.rd;

  // A flush cycle discards its dequeue along with everything else.
  assign deq = bus.frbus_rf_wb_vld && bus.rf_frbus_wb_ready && !bus.rtu_yy_xx_flush;

  // Datapath result is older in program order, so it takes the lower slot.
  assign fdsu_wptr = dp_acc ? wptr + PW'(1) : wptr;

  always_ff @(posedge forever_cpuclk) begin
    if (dp_acc) begin
      mem[wptr] <= '{data: bus.dp_frbus_ex2_data, fflags: bus.dp_frbus_ex2_fflags,
                     rd: bus.dp_frbus_ex2_rd};
    end
    if (fdsu_acc) begin
      mem[fdsu_wptr] <= '{data: bus.fdsu_frbus_data, fflags: bus.fdsu_frbus_fflags,
                          rd: bus.fdsu_frbus_rd};
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst || bus.rtu_yy_xx_flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + PW'(dp_acc) + PW'(fdsu_acc);
      rptr  <= rptr + PW'(deq);
      count <= count + CW'(dp_acc) + CW'(fdsu_acc) - CW'(deq);
    end
  end

`ifdef PA_FPU_FRBUS_FFLAGS_ACCUM_EN
  logic [4:0] fflags_acc;

  // Clear and dequeue in the same cycle keep only the dequeued flags.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      fflags_acc <= '0;
    end else if (bus.cp0_fpu_fflags_clr) begin
      fflags_acc <= deq ? head.fflags : 5'b0;
    end else if (deq) begin
      fflags_acc <= fflags_acc | head.fflags;
    end
  end

  assign bus.frbus_cp0_fflags = fflags_acc;
`else
  logic unused_fflags_clr;

  assign unused_fflags_clr    = bus.cp0_fpu_fflags_clr;
  assign bus.frbus_cp0_fflags = deq ? head.fflags : 5'b0;
`endif

endmodule

// File: tb/tb_pa_fpu_frbus_wb.sv
// tb_pa_fpu_frbus_wb
//   Directed bench for pa_fpu_frbus_wb at DEPTH = 4. Works in either build
//   of PA_FPU_FRBUS_FFLAGS_ACCUM_EN; flag expectations follow the build.
module tb_pa_fpu_frbus_wb;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pa_fpu_frbus_wb_if bus ();

  pa_fpu_frbus_wb #(.DEPTH(4)) dut (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .bus            (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dp_offer(input logic v, input logic [31:0] d, input logic [4:0] f,
                          input logic [4:0] r);
    bus.dp_frbus_ex2_vld    = v;
    bus.dp_frbus_ex2_data   = d;
    bus.dp_frbus_ex2_fflags = f;
    bus.dp_frbus_ex2_rd     = r;
  endtask

  task automatic fdsu_offer(input logic v, input logic [31:0] d, input logic [4:0] f,
                            input logic [4:0] r);
    bus.fdsu_frbus_vld    = v;
    bus.fdsu_frbus_data   = d;
    bus.fdsu_frbus_fflags = f;
    bus.fdsu_frbus_rd     = r;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    dp_offer(1'b0, 32'h0, 5'h0, 5'h0);
    fdsu_offer(1'b0, 32'h0, 5'h0, 5'h0);
    bus.rf_frbus_wb_ready  = 1'b0;
    bus.rtu_yy_xx_flush    = 1'b0;
    bus.cp0_fpu_fflags_clr = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;

    // reset state
    chk("rst_wb_vld", 32'(bus.frbus_rf_wb_vld), 32'd0);
    chk("rst_dp_ready", 32'(bus.frbus_dp_ready), 32'd1);
    chk("rst_fdsu_ready", 32'(bus.frbus_fdsu_ready), 32'd1);
    chk("rst_fflags", 32'(bus.frbus_cp0_fflags), 32'd0);

    // single datapath result, one cycle to offer, then consumed
    dp_offer(1'b1, 32'h3F80_0000, 5'h0, 5'd5);
    #1;
    chk("single_dp_ready", 32'(bus.frbus_dp_ready), 32'd1);
    step();
    dp_offer(1'b0, 32'h0, 5'h0, 5'h0);
    #1;
    chk("single_wb_vld", 32'(bus.frbus_rf_wb_vld), 32'd1);
    chk("single_wb_data", bus.frbus_rf_wb_data, 32'h3F80_0000);
    chk("single_wb_rd", 32'(bus.frbus_rf_wb_rd), 32'd5);
    bus.rf_frbus_wb_ready = 1'b1;
    step();
    bus.rf_frbus_wb_ready = 1'b0;
    #1;
    chk("single_empty", 32'(bus.frbus_rf_wb_vld), 32'd0);

    // same-cycle dp + fdsu, dp lands first
    dp_offer(1'b1, 32'hAAAA_0001, 5'b00001, 5'd1);
    fdsu_offer(1'b1, 32'hBBBB_0002, 5'b10000, 5'd2);
    #1;
    chk("dual_dp_ready", 32'(bus.frbus_dp_ready), 32'd1);
    chk("dual_fdsu_ready", 32'(bus.frbus_fdsu_ready), 32'd1);
    step();
    dp_offer(1'b0, 32'h0, 5'h0, 5'h0);
    fdsu_offer(1'b0, 32'h0, 5'h0, 5'h0);
    step();
    chk("dual_head_rd1", 32'(bus.frbus_rf_wb_rd), 32'd1);
    chk("dual_head_data1", bus.frbus_rf_wb_data, 32'hAAAA_0001);
    chk("dual_idle_fflags", 32'(bus.frbus_cp0_fflags), 32'd0);
    bus.rf_frbus_wb_ready = 1'b1;
    #1;
`ifdef PA_FPU_FRBUS_FFLAGS_ACCUM_EN
    chk("deq1_fflags", 32'(bus.frbus_cp0_fflags), 32'd0);
`else
    chk("deq1_fflags", 32'(bus.frbus_cp0_fflags), 32'b00001);
`endif
    step();
    chk("dual_head_rd2", 32'(bus.frbus_rf_wb_rd), 32'd2);
    chk("dual_head_data2", bus.frbus_rf_wb_data, 32'hBBBB_0002);
`ifdef PA_FPU_FRBUS_FFLAGS_ACCUM_EN
    chk("deq2_fflags", 32'(bus.frbus_cp0_fflags), 32'b00001);
`else
    chk("deq2_fflags", 32'(bus.frbus_cp0_fflags), 32'b10000);
`endif
    step();
    chk("dual_empty", 32'(bus.frbus_rf_wb_vld), 32'd0);
`ifdef PA_FPU_FRBUS_FFLAGS_ACCUM_EN
    chk("accum_fflags", 32'(bus.frbus_cp0_fflags), 32'b10001);
`else
    chk("accum_fflags", 32'(bus.frbus_cp0_fflags), 32'd0);
`endif
    bus.rf_frbus_wb_ready = 1'b0;

    // clear together with a dequeue
    dp_offer(1'b1, 32'hCCCC_0003, 5'b00100, 5'd3);
    step();
    dp_offer(1'b0, 32'h0, 5'h0, 5'h0);
    bus.rf_frbus_wb_ready  = 1'b1;
    bus.cp0_fpu_fflags_clr = 1'b1;
    #1;
`ifndef PA_FPU_FRBUS_FFLAGS_ACCUM_EN
    chk("clr_deq_live", 32'(bus.frbus_cp0_fflags), 32'b00100);
`endif
    step();
    bus.rf_frbus_wb_ready  = 1'b0;
    bus.cp0_fpu_fflags_clr = 1'b0;
    #1;
`ifdef PA_FPU_FRBUS_FFLAGS_ACCUM_EN
    chk("clr_deq_fflags", 32'(bus.frbus_cp0_fflags), 32'b00100);
    bus.cp0_fpu_fflags_clr = 1'b1;
    step();
    bus.cp0_fpu_fflags_clr = 1'b0;
    chk("clr_only_fflags", 32'(bus.frbus_cp0_fflags), 32'd0);
`else
    chk("clr_deq_fflags", 32'(bus.frbus_cp0_fflags), 32'd0);
`endif

    // fill to DEPTH with rf ready low
    for (int i = 0; i < 4; i++) begin
      dp_offer(1'b1, 32'h1000_0000 + 32'(i), 5'h0, 5'(10 + i));
      #1;
      chk($sformatf("fill_dp_ready_%0d", i), 32'(bus.frbus_dp_ready), 32'd1);
      chk($sformatf("fill_fdsu_ready_%0d", i), 32'(bus.frbus_fdsu_ready), (i == 3) ? 32'd0 : 32'd1);
      step();
    end
    chk("full_dp_ready", 32'(bus.frbus_dp_ready), 32'd0);
    chk("full_fdsu_ready", 32'(bus.frbus_fdsu_ready), 32'd0);
    bus.rf_frbus_wb_ready = 1'b1;
    #1;
    chk("full_deq_no_pass", 32'(bus.frbus_dp_ready), 32'd0);
    step();
    bus.rf_frbus_wb_ready = 1'b0;
    dp_offer(1'b0, 32'h0, 5'h0, 5'h0);
    #1;
    chk("after_full_dp_ready", 32'(bus.frbus_dp_ready), 32'd1);
    chk("after_full_fdsu_ready", 32'(bus.frbus_fdsu_ready), 32'd1);
    chk("after_full_head_rd", 32'(bus.frbus_rf_wb_rd), 32'd11);
    dp_offer(1'b1, 32'h0, 5'h0, 5'h0);
    bus.rtu_yy_xx_flush = 1'b1;
    #1;
    chk("three_fdsu_ready_dpvld", 32'(bus.frbus_fdsu_ready), 32'd0);
    bus.rtu_yy_xx_flush = 1'b0;
    dp_offer(1'b0, 32'h0, 5'h0, 5'h0);
    bus.rf_frbus_wb_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      #1;
      chk($sformatf("drain_rd_%0d", i), 32'(bus.frbus_rf_wb_rd), 32'(10 + i));
      chk($sformatf("drain_data_%0d", i), bus.frbus_rf_wb_data, 32'h1000_0000 + 32'(i));
      step();
    end
    bus.rf_frbus_wb_ready = 1'b0;
    #1;
    chk("drain_empty", 32'(bus.frbus_rf_wb_vld), 32'd0);

    // flush with three queued and a concurrent offer
    for (int i = 0; i < 3; i++) begin
      dp_offer(1'b1, 32'h2000_0000 + 32'(i), 5'h0, 5'(20 + i));
      step();
    end
    dp_offer(1'b1, 32'h3000_0000, 5'h0, 5'd30);
    bus.rtu_yy_xx_flush = 1'b1;
    #1;
    chk("flush_cycle_dp_ready", 32'(bus.frbus_dp_ready), 32'd1);
    step();
    bus.rtu_yy_xx_flush = 1'b0;
    dp_offer(1'b0, 32'h0, 5'h0, 5'h0);
    #1;
    chk("flush_wb_vld", 32'(bus.frbus_rf_wb_vld), 32'd0);
    chk("flush_fdsu_ready", 32'(bus.frbus_fdsu_ready), 32'd1);
    step();
    chk("flush_offer_dropped", 32'(bus.frbus_rf_wb_vld), 32'd0);

    // reset with two entries queued and rf ready high
    dp_offer(1'b1, 32'h4000_0007, 5'b00010, 5'd7);
    fdsu_offer(1'b1, 32'h4000_0008, 5'b01000, 5'd8);
    step();
    dp_offer(1'b0, 32'h0, 5'h0, 5'h0);
    fdsu_offer(1'b0, 32'h0, 5'h0, 5'h0);
    #1;
    chk("pre_rst_wb_vld", 32'(bus.frbus_rf_wb_vld), 32'd1);
    bus.rf_frbus_wb_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_wb_vld", 32'(bus.frbus_rf_wb_vld), 32'd0);
    chk("mid_rst_fflags", 32'(bus.frbus_cp0_fflags), 32'd0);
    chk("mid_rst_dp_ready", 32'(bus.frbus_dp_ready), 32'd1);
    chk("mid_rst_fdsu_ready", 32'(bus.frbus_fdsu_ready), 32'd1);
    bus.rf_frbus_wb_ready = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
